shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 157 +++++++++++++++
 tb/tb_shift_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-pass shift sequencer driving an external 16-bit barrel shifter (max 15 bits per pass).
// Optional macro SHIFT_SEQ_ASR_EN enables arithmetic right shift with sign fill via inversion.
//
// state | meaning
// IDLE  | waiting for a command, in_ready high
// EXEC  | one shifter pass per cycle until the remaining amount reaches zero
// DONE  | result and flags presented, waiting for out_ready
module shift_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [4:0]  in_amt,
   input  logic [15:0] in_data,
   output logic [3:0]  sh_shift,
   output logic        sh_lr,
   output logic [15:0] sh_in,
   input  logic [15:0] sh_out,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_z,
   output logic        out_n,
   output logic        out_c
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] work_q, work_d;
   logic [4:0]  rem_q, rem_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_data_q, out_data_d;
   logic        out_z_q, out_z_d;
   logic        out_n_q, out_n_d;
   logic        out_c_q, out_c_d;
`ifdef SHIFT_SEQ_ASR_EN
   logic        inv_q, inv_d;
`endif

   logic [3:0]  k;
   logic [4:0]  rem_next;
   logic        is_left;
   logic        carry;
   logic [15:0] shifter_in;
   logic [15:0] shifter_res;

   always_comb begin
      k        = (rem_q > 5'd15) ? 4'd15 : rem_q[3:0];
      rem_next = rem_q - {1'b0, k};
      is_left  = (op_q == 2'b00);
      // Carry is the last bit pushed out, taken from the true (uninverted) working value.
      if (k == 4'd0)
         carry = 1'b0;
      else if (is_left)
         carry = work_q[4'd0 - k];
      else
         carry = work_q[k - 4'd1];
`ifdef SHIFT_SEQ_ASR_EN
      shifter_in  = inv_q ? ~work_q : work_q;
      shifter_res = inv_q ? ~sh_out : sh_out;
`else
      shifter_in  = work_q;
      shifter_res = sh_out;
`endif
   end

   assign in_ready  = rst_n && (state_q == IDLE);
   assign sh_shift  = (state_q == EXEC) ? k : 4'd0;
   assign sh_lr     = (state_q == EXEC) && is_left;
   assign sh_in     = (state_q == EXEC) ? shifter_in : 16'h0000;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_z     = out_z_q;
   assign out_n     = out_n_q;
   assign out_c     = out_c_q;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      work_d      = work_q;
      rem_d       = rem_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_z_d     = out_z_q;
      out_n_d     = out_n_q;
      out_c_d     = out_c_q;
`ifdef SHIFT_SEQ_ASR_EN
      inv_d       = inv_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = in_op;
               work_d  = in_data;
               rem_d   = in_amt;
               state_d = EXEC;
`ifdef SHIFT_SEQ_ASR_EN
               inv_d   = (in_op == 2'b10) && in_data[15];
`endif
            end
         end
         EXEC: begin
            work_d = shifter_res;
            rem_d  = rem_next;
            if (rem_next == 5'd0) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               out_data_d  = shifter_res;
               out_z_d     = (shifter_res == 16'h0000);
               out_n_d     = shifter_res[15];
               out_c_d     = carry;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 2'b00;
         work_q      <= 16'h0000;
         rem_q       <= 5'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 16'h0000;
         out_z_q     <= 1'b0;
         out_n_q     <= 1'b0;
         out_c_q     <= 1'b0;
`ifdef SHIFT_SEQ_ASR_EN
         inv_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         work_q      <= work_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_z_q     <= out_z_d;
         out_n_q     <= out_n_d;
         out_c_q     <= out_c_d;
`ifdef SHIFT_SEQ_ASR_EN
         inv_q       <= inv_d;
`endif
      end
   end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: behavioural barrel shifter, whole-word reference model, directed and random commands.
module tb_shift_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [4:0]  in_amt;
   logic [15:0] in_data;
   logic [3:0]  sh_shift;
   logic        sh_lr;
   logic [15:0] sh_in;
   logic [15:0] sh_out;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_z, out_n, out_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   assign sh_out = sh_lr ? (sh_in << sh_shift) : (sh_in >> sh_shift);

   shift_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_amt(in_amt), .in_data(in_data),
      .sh_shift(sh_shift), .sh_lr(sh_lr), .sh_in(sh_in), .sh_out(sh_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_z(out_z), .out_n(out_n), .out_c(out_c)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Whole-word shift by the full amount; carry is the last bit shifted out. Returns {c, result}.
   function automatic logic [16:0] ref_shift(input logic [1:0] op, input logic [4:0] amt,
                                             input logic [15:0] data);
      logic [47:0]        w;
      logic signed [31:0] s;
      logic [15:0]        r;
      logic               c;
      if (op == 2'b00) begin
         w = {32'h0, data} << amt;
         r = w[15:0];
         c = w[16];
      end else begin
         w = {data, 32'h0} >> amt;
         r = w[47:32];
         c = w[31];
`ifdef SHIFT_SEQ_ASR_EN
         if (op == 2'b10) begin
            s = {{16{data[15]}}, data};
            s = s >>> amt;
            r = s[15:0];
            s = {{16{data[15]}}, data};
            c = (amt == 5'd0) ? 1'b0 : s[amt - 5'd1];
         end
`endif
      end
      return {c, r};
   endfunction

   task automatic run_cmd(input logic [1:0] op, input logic [4:0] amt, input logic [15:0] data,
                          input int hold);
      logic [16:0] r;
      logic [2:0]  fl;
      logic [3:0]  ks[8];
      logic        lrs[8];
      int          p, cyc, npass, rem, kexp, cnt;
      bit          done;
      r  = ref_shift(op, amt, data);
      fl = {r[15:0] == 16'h0, r[15], r[16]};
      p  = (amt == 5'd0) ? 1 : (int'(amt) + 14) / 15;
      @(negedge clk);
      cnt = 0;
      while (!in_ready && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      in_op    = op;
      in_amt   = amt;
      in_data  = data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      cyc = 0; npass = 0; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         if (npass < 8) begin
            ks[npass]  = sh_shift;
            lrs[npass] = sh_lr;
         end
         npass++;
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) done = 1;
      end
      chk("latency", cyc, p);
      rem = amt;
      for (int i = 0; i < p && i < 8 && i < npass; i++) begin
         kexp = (rem > 15) ? 15 : rem;
         chk("pass_k", ks[i], kexp);
         chk("pass_lr", lrs[i], (op == 2'b00));
         rem -= kexp;
      end
      chk("out_data", out_data, r[15:0]);
      chk("flags_znc", {out_z, out_n, out_c}, fl);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_op    = 2'($urandom);
         in_amt   = 5'($urandom);
         in_data  = 16'($urandom);
         #1;
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_data", {out_data, out_z, out_n, out_c}, {r[15:0], fl});
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
      chk("retain", {out_data, out_z, out_n, out_c}, {r[15:0], fl});
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_amt = 5'd0; in_data = 16'h0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out", {out_data, out_z, out_n, out_c}, 0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1);

      run_cmd(2'b00, 5'd1,  16'h8001, 0);
      run_cmd(2'b01, 5'd4,  16'h00F0, 0);
      run_cmd(2'b00, 5'd16, 16'h0001, 0);
      run_cmd(2'b00, 5'd31, 16'h0001, 0);
      run_cmd(2'b10, 5'd15, 16'h8000, 0);
      run_cmd(2'b00, 5'd0,  16'hA5A5, 1);
      run_cmd(2'b11, 5'd17, 16'hF00F, 0);
      run_cmd(2'b10, 5'd20, 16'hC003, 0);
      run_cmd(2'b01, 5'd3,  16'h1234, 5);

      // Abort during the second pass of a 31-bit shift.
      @(negedge clk);
      in_valid = 1'b1; in_op = 2'b00; in_amt = 5'd31; in_data = 16'h0001;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 0);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_out", {out_data, out_z, out_n, out_c}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_rel_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_valid", out_valid, 0);
      end
      run_cmd(2'b00, 5'd1, 16'h0003, 0);

      for (int i = 0; i < 40; i++)
         run_cmd(2'($urandom), 5'($urandom), 16'($urandom), int'($urandom_range(0, 3)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
